xyz_uart_streamer: RTL and testbench



---
 rtl/xyz_stream_pkg.sv | 35 +++
 rtl/xyz_sample_fifo.sv | 56 +++++
 rtl/xyz_uart_streamer.sv | 165 ++++++++++++++++
 tb/tb_xyz_uart_streamer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xyz_stream_pkg.sv
// Shared types and constants for the XYZ UART streamer.
//   SYNC_BYTE   : first byte of every frame
//   FRAME_BYTES : sync byte + three 32-bit big-endian coordinates
//   INT_W/FRAC_W: Q11.17 coordinate format, COORD_W = 28
//   tx_state_t  : serialiser FSM states
//   sample_t    : one captured (x, y, z) result
//   sext32      : sign-extend a coordinate to 32 bits for transmission
package xyz_stream_pkg;

  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam int unsigned FRAME_BYTES = 13;
  localparam int unsigned FRAME_W     = FRAME_BYTES * 8;
  localparam int unsigned INT_W       = 11;
  localparam int unsigned FRAC_W      = 17;
  localparam int unsigned COORD_W     = INT_W + FRAC_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } sample_t;

  function automatic logic [31:0] sext32(input logic [COORD_W-1:0] v);
    return 32'($signed(v));
  endfunction

endpackage

// File: rtl/xyz_sample_fifo.sv
// First-word-fall-through FIFO of captured samples.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored when full unless popping)
//   pop        : remove head (ignored when empty)
//   full/empty : occupancy flags
//   head       : current head entry, valid whenever !empty
module xyz_sample_fifo
  import xyz_stream_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  sample_t din,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output sample_t head
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  sample_t          mem_q [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (PTR_W+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/xyz_uart_streamer.sv
// Captures (X, Y, Z) on each rising FINISHED_i, queues it, and sends each
// sample as a 13-byte 8N1 frame: A5, then X, Y, Z sign-extended to 32 bits,
// big-endian.
//   CLK_i, RSTN_i : clock, asynchronous active-low reset
//   FINISHED_i    : integrator done level, captured on its rising edge
//   X_i/Y_i/Z_i   : Q11.17 coordinates
//   TX_o          : UART line, idle high
//   BUSY_o        : queue non-empty or frame in flight
//   OVERFLOW_o    : sticky, a sample was dropped on a full queue
module xyz_uart_streamer
  import xyz_stream_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned DATA_W      = 28,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic              CLK_i,
  input  logic              RSTN_i,
  input  logic              FINISHED_i,
  input  logic [DATA_W-1:0] X_i,
  input  logic [DATA_W-1:0] Y_i,
  input  logic [DATA_W-1:0] Z_i,
  output logic              TX_o,
  output logic              BUSY_o,
  output logic              OVERFLOW_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("CLK_FREQ_HZ/BAUD must be at least 2");
  end
  if (DATA_W != COORD_W) begin : g_bad_width
    $error("DATA_W must equal INT_W+FRAC_W");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [3:0]         byte_idx_q, byte_idx_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic               finished_q, finished_d;

  logic               push_req, push_ok, pop;
  logic               fifo_full, fifo_empty;
  logic               bit_done;
  logic [7:0]         cur_byte;
  sample_t            sample_in, head;

  assign finished_d = FINISHED_i;
  assign push_req   = FINISHED_i & ~finished_q;
  assign sample_in  = {X_i, Y_i, Z_i};
  assign bit_done   = (cnt_q == CNT_LAST);

  xyz_sample_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK_i),
    .rst_n (RSTN_i),
    .push  (push_req),
    .din   (sample_in),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    frame_d    = frame_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty) state_d = LOAD;
      LOAD: begin
        pop        = 1'b1;
        frame_d    = {SYNC_BYTE, sext32(head.x), sext32(head.y), sext32(head.z)};
        byte_idx_d = '0;
        cnt_d      = '0;
        state_d    = START;
      end
      START: begin
        if (bit_done) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          if (byte_idx_q != LAST_BYTE) begin
            byte_idx_d = byte_idx_q + 4'd1;
            frame_d    = frame_q << 8;
            state_d    = START;
          end else if (!fifo_empty) state_d = LOAD;
          else state_d = IDLE;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Line level is derived from the next state so TX_o is a plain flop.
    cur_byte = frame_d[FRAME_W-1 -: 8];
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_idx_d];
      default: tx_d = 1'b1;
    endcase

    // Busy is registered from next-cycle terms so it drops with the last
    // stop bit; an accepted push makes the queue non-empty next cycle.
    push_ok = push_req & (~fifo_full | pop);
    busy_d  = (state_d != IDLE) | ~fifo_empty | push_ok;
    ovf_d   = ovf_q | (push_req & fifo_full & ~pop);
  end

  always_ff @(posedge CLK_i or negedge RSTN_i) begin
    if (!RSTN_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      frame_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      finished_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      frame_q    <= frame_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      finished_q <= finished_d;
    end
  end

  assign TX_o       = tx_q;
  assign BUSY_o     = busy_q;
  assign OVERFLOW_o = ovf_q;

endmodule

// File: tb/tb_xyz_uart_streamer.sv
module tb_xyz_uart_streamer;

  localparam int CLK_FREQ_HZ = 1000;
  localparam int BAUD        = 100;
  localparam int C           = CLK_FREQ_HZ / BAUD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fin = 1'b0;
  logic [27:0] x = '0, y = '0, z = '0;
  logic        tx, busy, ovf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xyz_uart_streamer #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD       (BAUD),
    .DATA_W     (28),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK_i      (clk),
    .RSTN_i     (rst_n),
    .FINISHED_i (fin),
    .X_i        (x),
    .Y_i        (y),
    .Z_i        (z),
    .TX_o       (tx),
    .BUSY_o     (busy),
    .OVERFLOW_o (ovf)
  );

  typedef struct {
    logic [27:0]  x;
    logic [27:0]  y;
    logic [27:0]  z;
    logic [103:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: Q11.17 value as an integer, wrapped to 32-bit two's complement.
  function automatic logic [31:0] to32(input logic [27:0] v);
    longint s;
    s = longint'(v);
    if (v >= 28'h8000000) s = s - (longint'(1) << 28);
    return s[31:0];
  endfunction

  function automatic logic [103:0] model_frame(input logic [27:0] a, input logic [27:0] b,
                                               input logic [27:0] c);
    return {8'hA5, to32(a), to32(b), to32(c)};
  endfunction

  task automatic pulse(input logic [27:0] a, input logic [27:0] b, input logic [27:0] c,
                       output int cap);
    @(negedge clk);
    x = a; y = b; z = c; fin = 1'b1;
    @(negedge clk);
    cap = cyc;
    fin = 1'b0;
  endtask

  task automatic rx_check(input string name, input logic [103:0] exp, output int start_cyc);
    logic [103:0] f;
    logic [7:0]   by;
    int           budget, prev;
    bit           framing_bad, spacing_bad;
    f = '0; by = '0; framing_bad = 0; spacing_bad = 0; start_cyc = -1; prev = 0;
    for (int b = 0; b < 13; b++) begin
      budget = 4000;
      while (tx !== 1'b0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (tx !== 1'b0) begin
        chk({name, "_timeout"}, 1, 0);
        return;
      end
      if (b == 0) start_cyc = cyc;
      else if (cyc - prev != 10 * C) spacing_bad = 1;
      prev = cyc;
      repeat (C / 2) @(negedge clk);
      if (tx !== 1'b0) framing_bad = 1;
      for (int i = 0; i < 8; i++) begin
        repeat (C) @(negedge clk);
        by[i] = tx;
      end
      repeat (C) @(negedge clk);
      if (tx !== 1'b1) framing_bad = 1;
      f = {f[95:0], by};
    end
    chk(name, f, exp);
    chk({name, "_framing"}, framing_bad, 0);
    chk({name, "_spacing"}, spacing_bad, 0);
  endtask

  task automatic wait_idle(input string name);
    int budget;
    budget = 3000;
    while (busy === 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (busy !== 1'b0) chk({name, "_idle_timeout"}, 1, 0);
  endtask

  task automatic quiet_window(input string name, input int n);
    int lows;
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk(name, lows, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[3];
    int          cap, st, lat, budget;
    logic [27:0] ya[6], za[6];
    logic [27:0] rx_[8], ry[8], rz[8];

    vecs[0] = '{28'h7FFFFFF, 28'h8000000, 28'h0000001,
                104'hA5_07FFFFFF_F8000000_00000001};
    vecs[1] = '{28'hFFFFFFF, 28'h0000000, 28'h1234567,
                104'hA5_FFFFFFFF_00000000_01234567};
    vecs[2] = '{28'h0020000, 28'hFFE0000, 28'h0000000,
                104'hA5_00020000_FFFE0000_00000000};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_ovf", ovf, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Spec vector with latency checks
    pulse(28'h0020000, 28'hFFE0000, 28'h0000000, cap);
    budget = 10;
    while (tx !== 1'b0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    lat = cyc - cap;
    chk("t1_start_latency", lat, 2);
    rx_check("t1_frame", 104'hA5_00020000_FFFE0000_00000000, st);
    wait_idle("t1");
    chk("t1_busy_fall", cyc - cap, 1302);
    chk("t1_ovf", ovf, 0);

    // Table-driven boundary values
    for (int i = 0; i < 3; i++) begin
      pulse(vecs[i].x, vecs[i].y, vecs[i].z, cap);
      rx_check($sformatf("tbl%0d", i), vecs[i].exp, st);
      wait_idle($sformatf("tbl%0d", i));
    end

    // FINISHED held high for 50 cycles: one capture only
    x = 28'h0000ABC; y = 28'h8000001; z = 28'h0000010;
    fork
      begin
        @(negedge clk);
        fin = 1'b1;
        repeat (50) @(negedge clk);
        fin = 1'b0;
      end
      rx_check("t3_frame", model_frame(28'h0000ABC, 28'h8000001, 28'h0000010), st);
    join
    quiet_window("t3_single_frame", 1500);
    chk("t3_ovf", ovf, 0);

    // Six pulses 20 cycles apart: five frames, sixth dropped
    for (int k = 0; k < 6; k++) begin
      ya[k] = 28'($urandom());
      za[k] = 28'($urandom());
    end
    fork
      begin
        int pcap;
        for (int k = 1; k <= 6; k++) begin
          pulse(28'(k), ya[k-1], za[k-1], pcap);
          repeat (18) @(negedge clk);
        end
      end
      begin
        int fst, pst;
        pst = 0;
        for (int k = 0; k < 5; k++) begin
          rx_check($sformatf("t4_frame%0d", k + 1), model_frame(28'(k + 1), ya[k], za[k]), fst);
          if (k > 0) chk($sformatf("t4_gap%0d", k), fst - pst, 1301);
          pst = fst;
        end
      end
    join
    chk("t4_ovf", ovf, 1);
    wait_idle("t4");
    quiet_window("t4_no_sixth", 1500);
    chk("t4_ovf_sticky", ovf, 1);

    // Reset during byte 5 of a frame
    pulse(28'h0000111, 28'h0000222, 28'h0000333, cap);
    budget = 10;
    while (tx !== 1'b0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (tx !== 1'b0) chk("t5_start_timeout", 1, 0);
    repeat (530) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_tx", tx, 1);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ovf", ovf, 0);
    quiet_window("t5_quiet_in_reset", 200);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pulse(28'h0ABCDEF, 28'h0000042, 28'hF000000, cap);
    rx_check("t5_clean_frame", model_frame(28'h0ABCDEF, 28'h0000042, 28'hF000000), st);
    wait_idle("t5");

    // X_i changes one cycle after capture
    pulse(28'h0000001, 28'h0000007, 28'h0000009, cap);
    x = 28'h1234567;
    rx_check("t6_frame", model_frame(28'h0000001, 28'h0000007, 28'h0000009), st);
    wait_idle("t6");

    // FINISHED high throughout reset release
    @(negedge clk);
    rst_n = 1'b0;
    fin = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet_window("t7_no_frame", 2000);
    chk("t7_busy", busy, 0);
    fin = 1'b0;
    repeat (3) @(negedge clk);

    // Randomised bursts against the reference model
    for (int i = 0; i < 8; i++) begin
      rx_[i] = 28'($urandom());
      ry[i]  = 28'($urandom());
      rz[i]  = 28'($urandom());
    end
    for (int base = 0; base < 8; base += 3) begin
      int nb;
      nb = (8 - base < 3) ? 8 - base : 3;
      fork
        begin
          int pcap;
          for (int j = 0; j < nb; j++) begin
            pulse(rx_[base+j], ry[base+j], rz[base+j], pcap);
            repeat ($urandom_range(8, 1)) @(negedge clk);
          end
        end
        begin
          int fst;
          for (int j = 0; j < nb; j++)
            rx_check($sformatf("rand%0d", base + j),
                     model_frame(rx_[base+j], ry[base+j], rz[base+j]), fst);
        end
      join
      wait_idle($sformatf("rand_burst%0d", base));
    end
    chk("rand_ovf", ovf, 0);
    chk("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
